// File: rtl/nv_nvdla_mcif_wr_sched_pkg.sv
// Shared types and constants for the MCIF write-ingress scheduler.
// Optional stall counter is enabled by NVDLA_MCIF_WR_SCHED_STALL_CNT_EN.
package nv_nvdla_mcif_wr_pkg;

    localparam int unsigned NUM_CLIENT = 5;
    localparam int unsigned LEN_W      = 2;
    localparam int unsigned OS_W       = 9;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned WT_W       = 8;
    localparam int unsigned GCNT_W     = 9;
    localparam int unsigned OSX_W      = OS_W + 2;

    localparam logic [IDX_W-1:0] CLIENT_BDMA = 3'd0;
    localparam logic [IDX_W-1:0] CLIENT_SDP  = 3'd1;
    localparam logic [IDX_W-1:0] CLIENT_PDP  = 3'd2;
    localparam logic [IDX_W-1:0] CLIENT_CDP  = 3'd3;
    localparam logic [IDX_W-1:0] CLIENT_RBK  = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    // Context of the packet currently owning the downstream channel.
    typedef struct packed {
        logic [IDX_W-1:0] sel;
        logic [LEN_W-1:0] beats_left;
    } pkt_ctx_t;

endpackage

// File: rtl/nv_nvdla_mcif_wr_sched_if.sv
// Client/downstream/register bundle of the MCIF write scheduler.
interface nv_nvdla_mcif_wr_sched_if;
    import nv_nvdla_mcif_wr_pkg::*;

    logic [NUM_CLIENT-1:0]       cmd_valid;
    logic [NUM_CLIENT*LEN_W-1:0] cmd_len;
    logic [NUM_CLIENT-1:0]       cmd_ready;
    logic [NUM_CLIENT-1:0]       dat_valid;
    logic [NUM_CLIENT-1:0]       dat_ready;
    logic                        out_cmd_valid;
    logic                        out_cmd_ready;
    logic                        out_dat_valid;
    logic                        out_dat_ready;
    logic [IDX_W-1:0]            sel;
    logic [NUM_CLIENT*WT_W-1:0]  reg2dp_wr_weight;
    logic [7:0]                  reg2dp_wr_os_cnt;
    logic                        eg2ig_axi_vld;
    logic [1:0]                  eg2ig_axi_len;

    // Scheduler side.
    modport slave (
        input  cmd_valid, cmd_len, dat_valid, out_cmd_ready, out_dat_ready,
        input  reg2dp_wr_weight, reg2dp_wr_os_cnt, eg2ig_axi_vld, eg2ig_axi_len,
        output cmd_ready, dat_ready, out_cmd_valid, out_dat_valid, sel
    );

    // Requester / downstream / register side.
    modport master (
        output cmd_valid, cmd_len, dat_valid, out_cmd_ready, out_dat_ready,
        output reg2dp_wr_weight, reg2dp_wr_os_cnt, eg2ig_axi_vld, eg2ig_axi_len,
        input  cmd_ready, dat_ready, out_cmd_valid, out_dat_valid, sel
    );

endinterface

// File: rtl/nv_nvdla_mcif_wr_sched_rr_pick.sv
// Combinational rotating-priority picker: first request above ptr_i, wrapping.
module nv_nvdla_mcif_wr_rr_pick #(
    parameter int unsigned N     = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    logic found;
    int   cand;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= int'(N); k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= int'(N)) cand = cand - int'(N);
            for (int j = 0; j < int'(N); j++) begin
                if (!found && (j == cand) && req_i[j]) begin
                    found        = 1'b1;
                    gnt_oh_o[j]  = 1'b1;
                    gnt_idx_o    = IDX_W'(j);
                end
            end
        end
        gnt_vld_o = found;
    end

endmodule

// File: rtl/nv_nvdla_mcif_wr_sched.sv
// Weighted round-robin, packet-atomic write scheduler with outstanding-beat throttle.
// Optional stall counter ports exist only with NVDLA_MCIF_WR_SCHED_STALL_CNT_EN.
module nv_nvdla_mcif_wr_sched
    import nv_nvdla_mcif_wr_pkg::*;
(
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
`ifdef NVDLA_MCIF_WR_SCHED_STALL_CNT_EN
    input  logic        stall_cnt_clr,
    output logic [31:0] stall_cnt,
`endif
    nv_nvdla_mcif_wr_sched_if.slave bus
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GCNT_W-1:0] gcnt_q [NUM_CLIENT];
    logic [GCNT_W-1:0] gcnt_d [NUM_CLIENT];
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    pkt_ctx_t          ctx_q, ctx_d;

    logic [LEN_W-1:0]      len_c [NUM_CLIENT];
    logic [NUM_CLIENT-1:0] os_fit, wt_ok, req_os, elig_wt, pick_req, win_oh;
    logic [IDX_W-1:0]      win_idx;
    logic [LEN_W-1:0]      win_len;
    logic                  win_vld, round_rst, grant;

    logic [NUM_CLIENT-1:0] cmd_ready_c, dat_ready_c;
    logic                  out_cmd_valid_c, out_dat_valid_c;
    logic [IDX_W-1:0]      sel_c;
    logic [OSX_W-1:0]      os_sum, os_sub;

    // Eligibility: OS room, weight budget, and round reset when only weight blocks.
    always_comb begin
        os_fit = '0;
        wt_ok  = '0;
        for (int i = 0; i < int'(NUM_CLIENT); i++) begin
            len_c[i]  = bus.cmd_len[i*LEN_W +: LEN_W];
            os_fit[i] = (OSX_W'(os_cnt_q) + OSX_W'(len_c[i]) + OSX_W'(1))
                        <= (OSX_W'(bus.reg2dp_wr_os_cnt) + OSX_W'(1));
            wt_ok[i]  = gcnt_q[i] <= GCNT_W'(bus.reg2dp_wr_weight[i*WT_W +: WT_W]);
        end
        req_os    = bus.cmd_valid & os_fit;
        elig_wt   = req_os & wt_ok;
        round_rst = (state_q == IDLE) && (req_os != '0) && (elig_wt == '0);
        pick_req  = (state_q != IDLE) ? '0 : (round_rst ? req_os : elig_wt);
    end

    nv_nvdla_mcif_wr_rr_pick #(
        .N     (NUM_CLIENT),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (pick_req),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (win_oh),
        .gnt_idx_o (win_idx),
        .gnt_vld_o (win_vld)
    );

    always_comb begin
        win_len = '0;
        for (int i = 0; i < int'(NUM_CLIENT); i++) begin
            if (win_oh[i]) win_len = len_c[i];
        end
    end

    assign grant = win_vld && bus.out_cmd_ready;

    // Next-state and handshake outputs.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        ctx_d           = ctx_q;
        gcnt_d          = gcnt_q;
        cmd_ready_c     = '0;
        dat_ready_c     = '0;
        out_cmd_valid_c = 1'b0;
        out_dat_valid_c = 1'b0;
        sel_c           = '0;
        unique case (state_q)
            IDLE: begin
                out_cmd_valid_c = win_vld;
                sel_c           = win_idx;
                cmd_ready_c     = win_oh & {NUM_CLIENT{bus.out_cmd_ready}};
                if (round_rst) begin
                    for (int i = 0; i < int'(NUM_CLIENT); i++) gcnt_d[i] = '0;
                end
                if (grant) begin
                    rr_ptr_d = win_idx;
                    ctx_d    = '{sel: win_idx, beats_left: win_len};
                    state_d  = DATA;
                    for (int i = 0; i < int'(NUM_CLIENT); i++) begin
                        if (win_oh[i] && (gcnt_d[i] != '1)) gcnt_d[i] = gcnt_d[i] + GCNT_W'(1);
                    end
                end
            end
            DATA: begin
                sel_c = ctx_q.sel;
                for (int i = 0; i < int'(NUM_CLIENT); i++) begin
                    if (ctx_q.sel == IDX_W'(i)) begin
                        out_dat_valid_c = bus.dat_valid[i];
                        dat_ready_c[i]  = bus.out_dat_ready;
                    end
                end
                if (out_dat_valid_c && bus.out_dat_ready) begin
                    if (ctx_q.beats_left == '0) state_d = IDLE;
                    else ctx_d.beats_left = ctx_q.beats_left - LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Net outstanding-beat delta: grant adds, completion subtracts, floor at 0.
    always_comb begin
        os_sum   = OSX_W'(os_cnt_q) + (grant ? (OSX_W'(win_len) + OSX_W'(1)) : '0);
        os_sub   = bus.eg2ig_axi_vld ? (OSX_W'(bus.eg2ig_axi_len) + OSX_W'(1)) : '0;
        os_cnt_d = (os_sum > os_sub) ? OS_W'(os_sum - os_sub) : '0;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDX_W'(NUM_CLIENT - 1);
            os_cnt_q <= '0;
            ctx_q    <= '0;
            for (int i = 0; i < int'(NUM_CLIENT); i++) gcnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            os_cnt_q <= os_cnt_d;
            ctx_q    <= ctx_d;
            for (int i = 0; i < int'(NUM_CLIENT); i++) gcnt_q[i] <= gcnt_d[i];
        end
    end

    // Handshakes are forced quiet while reset is held, even mid-packet.
    assign bus.out_cmd_valid = out_cmd_valid_c & nvdla_core_rstn;
    assign bus.out_dat_valid = out_dat_valid_c & nvdla_core_rstn;
    assign bus.cmd_ready     = cmd_ready_c & {NUM_CLIENT{nvdla_core_rstn}};
    assign bus.dat_ready     = dat_ready_c & {NUM_CLIENT{nvdla_core_rstn}};
    assign bus.sel           = sel_c & {IDX_W{nvdla_core_rstn}};

`ifdef NVDLA_MCIF_WR_SCHED_STALL_CNT_EN
    // With round reset, an idle cycle with requests but no winner means every requester is OS-blocked.
    logic [31:0] stall_cnt_q;
    logic        stall_hit;

    assign stall_hit = (state_q == IDLE) && (bus.cmd_valid != '0) && !win_vld;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)                   stall_cnt_q <= '0;
        else if (stall_cnt_clr)                 stall_cnt_q <= '0;
        else if (stall_hit && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'(1);
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_mcif_wr_sched.sv
// Directed scoreboard bench for nv_nvdla_mcif_wr_sched.
module tb_nv_nvdla_mcif_wr_sched;
    import nv_nvdla_mcif_wr_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nv_nvdla_mcif_wr_sched_if bus ();

`ifdef NVDLA_MCIF_WR_SCHED_STALL_CNT_EN
    logic        stall_cnt_clr = 1'b0;
    logic [31:0] stall_cnt;
`endif

    nv_nvdla_mcif_wr_sched dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
`ifdef NVDLA_MCIF_WR_SCHED_STALL_CNT_EN
        .stall_cnt_clr   (stall_cnt_clr),
        .stall_cnt       (stall_cnt),
`endif
        .bus             (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.cmd_valid     = '0;
        bus.cmd_len       = '0;
        bus.dat_valid     = '0;
        bus.eg2ig_axi_vld = 1'b0;
        bus.eg2ig_axi_len = '0;
    endtask

    task automatic set_len(input int c, input int l);
        bus.cmd_len[c*LEN_W +: LEN_W] = LEN_W'(l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        quiet_inputs();
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Caller sits at a negedge with requests driven; waits up to budget cycles for a cmd.
    task automatic wait_grant(input string tag, input int budget);
        int n;
        int e;
        n = 0;
        #1;
        while (!bus.out_cmd_valid && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 7;
        chk({tag, "_vld"}, 32'(bus.out_cmd_valid), 32'(1));
        chk({tag, "_sel"}, 32'(bus.sel), 32'(e));
        chk({tag, "_rdy"}, 32'(bus.cmd_ready), (e < 5) ? (32'(1) << e) : 32'(0));
    endtask

    // Streams len+1 beats for client c, then checks the idle cycle that follows.
    task automatic run_data(input string tag, input int c, input int len, input bit drop_cmd);
        for (int b = 0; b <= len; b++) begin
            @(negedge clk);
            if (drop_cmd) bus.cmd_valid = '0;
            bus.eg2ig_axi_vld = 1'b0;
            bus.dat_valid     = 5'(1 << c);
            #1;
            chk({tag, "_dsel"}, 32'(bus.sel), 32'(c));
            chk({tag, "_dvld"}, 32'(bus.out_dat_valid), 32'(1));
            chk({tag, "_drdy"}, 32'(bus.dat_ready), 32'(1) << c);
            chk({tag, "_dcmd"}, 32'(bus.out_cmd_valid), 32'(0));
        end
        @(negedge clk);
        bus.dat_valid = '0;
        #1;
        chk({tag, "_idle_drdy"}, 32'(bus.dat_ready), 32'(0));
        chk({tag, "_idle_dvld"}, 32'(bus.out_dat_valid), 32'(0));
    endtask

    initial begin
        int pat [12];
        pat = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

        quiet_inputs();
        bus.out_cmd_ready    = 1'b1;
        bus.out_dat_ready    = 1'b1;
        bus.reg2dp_wr_weight = {5{8'd1}};
        bus.reg2dp_wr_os_cnt = 8'd255;

        // Single client 2, len 3; then OS hold and release by completion.
        do_reset();
        #1;
        chk("rst_cmd_vld", 32'(bus.out_cmd_valid), 32'(0));
        chk("rst_sel",     32'(bus.sel), 32'(0));
        chk("rst_cmd_rdy", 32'(bus.cmd_ready), 32'(0));
        chk("rst_dat_rdy", 32'(bus.dat_ready), 32'(0));
        set_len(2, 3);
        bus.cmd_valid = 5'b00100;
        exp_q.push_back(2);
        wait_grant("t1", 0);
        run_data("t1", 2, 3, 1'b1);
        bus.reg2dp_wr_os_cnt = 8'd4;
        set_len(2, 1);
        bus.cmd_valid = 5'b00100;
        #1;
        chk("t1_os_hold", 32'(bus.out_cmd_valid), 32'(0));
        @(negedge clk);
        bus.eg2ig_axi_vld = 1'b1;
        bus.eg2ig_axi_len = 2'd3;
        #1;
        chk("t1_os_hold2", 32'(bus.out_cmd_valid), 32'(0));
        @(negedge clk);
        bus.eg2ig_axi_vld = 1'b0;
        exp_q.push_back(2);
        wait_grant("t1_rel", 0);
        run_data("t1_rel", 2, 1, 1'b1);

        // Weighted round robin: weights 2 and 0, len 0.
        do_reset();
        bus.reg2dp_wr_weight = 40'h00_00_00_00_02;
        bus.reg2dp_wr_os_cnt = 8'd255;
        bus.cmd_valid = 5'b00011;
        bus.dat_valid = 5'b11111;
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(pat[k]);
            wait_grant($sformatf("t2_g%0d", k), 2);
            @(negedge clk);
            #1;
            chk($sformatf("t2_d%0d", k), 32'(bus.dat_ready), 32'(1) << pat[k]);
            @(negedge clk);
        end
        quiet_inputs();
        bus.reg2dp_wr_weight = {5{8'd1}};

        // OS limit 3 (4 beats): second len-3 packet waits for one completion.
        do_reset();
        bus.reg2dp_wr_os_cnt = 8'd3;
        set_len(0, 3);
        bus.cmd_valid = 5'b00001;
        exp_q.push_back(0);
        wait_grant("t3a", 0);
        run_data("t3a", 0, 3, 1'b0);
        chk("t3_hold_vld", 32'(bus.out_cmd_valid), 32'(0));
        chk("t3_hold_rdy", 32'(bus.cmd_ready), 32'(0));
        @(negedge clk);
        #1;
        chk("t3_hold_vld2", 32'(bus.out_cmd_valid), 32'(0));
        @(negedge clk);
        bus.eg2ig_axi_vld = 1'b1;
        bus.eg2ig_axi_len = 2'd3;
        #1;
        chk("t3_hold_vld3", 32'(bus.out_cmd_valid), 32'(0));
        @(negedge clk);
        bus.eg2ig_axi_vld = 1'b0;
        exp_q.push_back(0);
        wait_grant("t3b", 0);
        run_data("t3b", 0, 3, 1'b1);

        // Same-cycle grant (len 1) and completion (len 0) from os_cnt 2 leaves 3.
        do_reset();
        bus.reg2dp_wr_os_cnt = 8'd3;
        set_len(0, 1);
        bus.cmd_valid = 5'b00001;
        exp_q.push_back(0);
        wait_grant("t4a", 0);
        run_data("t4a", 0, 1, 1'b1);
        bus.cmd_valid     = 5'b00001;
        bus.eg2ig_axi_vld = 1'b1;
        bus.eg2ig_axi_len = 2'd0;
        exp_q.push_back(0);
        wait_grant("t4b", 0);
        run_data("t4b", 0, 1, 1'b1);
        set_len(0, 1);
        bus.cmd_valid = 5'b00001;
        #1;
        chk("t4_len1_hold", 32'(bus.out_cmd_valid), 32'(0));
        @(negedge clk);
        set_len(0, 0);
        exp_q.push_back(0);
        wait_grant("t4_len0", 0);
        run_data("t4_len0", 0, 0, 1'b1);

        // Backpressure mid-packet while another client requests.
        do_reset();
        bus.reg2dp_wr_os_cnt = 8'd255;
        set_len(1, 3);
        bus.cmd_valid = 5'b00010;
        exp_q.push_back(1);
        wait_grant("t5a", 0);
        @(negedge clk);
        bus.cmd_valid = '0;
        bus.dat_valid = 5'b00010;
        #1;
        chk("t5_b0_rdy", 32'(bus.dat_ready), 32'(5'b00010));
        @(negedge clk);
        bus.out_dat_ready = 1'b0;
        set_len(3, 0);
        bus.cmd_valid = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t5_stall%0d_crdy", i), 32'(bus.cmd_ready), 32'(0));
            chk($sformatf("t5_stall%0d_cvld", i), 32'(bus.out_cmd_valid), 32'(0));
            chk($sformatf("t5_stall%0d_drdy", i), 32'(bus.dat_ready), 32'(0));
            chk($sformatf("t5_stall%0d_sel", i), 32'(bus.sel), 32'(1));
            @(negedge clk);
        end
        bus.out_dat_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            #1;
            chk($sformatf("t5_b%0d_crdy", b), 32'(bus.cmd_ready), 32'(0));
            chk($sformatf("t5_b%0d_drdy", b), 32'(bus.dat_ready), 32'(5'b00010));
            @(negedge clk);
        end
        bus.dat_valid = '0;
        exp_q.push_back(3);
        wait_grant("t5b", 0);
        run_data("t5b", 3, 0, 1'b1);

        // Reset in DATA with beats_left 2; first grant afterwards goes to client 0.
        do_reset();
        set_len(2, 3);
        bus.cmd_valid = 5'b00100;
        exp_q.push_back(2);
        wait_grant("t6a", 0);
        @(negedge clk);
        bus.cmd_valid = '0;
        bus.dat_valid = 5'b00100;
        @(negedge clk);
        set_len(4, 0);
        set_len(0, 0);
        bus.cmd_valid = 5'b10001;
        rstn = 1'b0;
        #1;
        chk("t6_rst_cvld", 32'(bus.out_cmd_valid), 32'(0));
        chk("t6_rst_dvld", 32'(bus.out_dat_valid), 32'(0));
        chk("t6_rst_crdy", 32'(bus.cmd_ready), 32'(0));
        chk("t6_rst_drdy", 32'(bus.dat_ready), 32'(0));
        chk("t6_rst_sel",  32'(bus.sel), 32'(0));
        @(negedge clk);
        rstn = 1'b1;
        bus.dat_valid = '0;
        exp_q.push_back(0);
        wait_grant("t6b", 0);
        run_data("t6b", 0, 0, 1'b1);

        chk("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_mcif_wr_sched.md
Name: nv_nvdla_mcif_wr_sched

Overview:
Weighted round-robin scheduler for the MCIF write ingress path. It shares the single downstream cmd/data channel among NUM_CLIENT write requesters (bdma, sdp, pdp, cdp, rbk).
- Each grant is packet-atomic: one cmd, then exactly len+1 data beats from the same client.
- New grants are throttled by an outstanding-beat counter, credited back by egress completions.

Parameters:
NUM_CLIENT, 5, number of requesters; index 0 = bdma … 4 = rbk
LEN_W, 2, width of per-request beat length field (beats-1)
OS_W, 9, width of the outstanding-beat counter

Ports:
nvdla_core_clk  in  1  clock
nvdla_core_rstn  in  1  async reset, active low
cmd_valid  in  NUM_CLIENT  per-client cmd valid
cmd_len  in  NUM_CLIENT*LEN_W  per-client beats-1, client i at [i*LEN_W +: LEN_W]
cmd_ready  out  NUM_CLIENT  per-client cmd accept
dat_valid  in  NUM_CLIENT  per-client data valid
dat_ready  out  NUM_CLIENT  per-client data accept
out_cmd_valid  out  1  downstream cmd valid
out_cmd_ready  in  1  downstream cmd ready
out_dat_valid  out  1  downstream data valid
out_dat_ready  in  1  downstream data ready
sel  out  3  client index driving the datapath mux
reg2dp_wr_weight  in  NUM_CLIENT*8  per-client weight
reg2dp_wr_os_cnt  in  8  outstanding limit minus 1
eg2ig_axi_vld  in  1  write completion pulse
eg2ig_axi_len  in  2  completed beats-1

Behaviour:
- Clock and reset: one clock, nvdla_core_clk. Reset nvdla_core_rstn is asynchronous and active-low.
- Reset values: state=IDLE, rr_ptr=NUM_CLIENT-1, all grant counters 0, os_cnt 0, sel 0. All valid/ready outputs 0.
- States: IDLE and DATA.
- Eligibility in IDLE: client i is eligible if all of the following hold:
  - cmd_valid[i]=1;
  - gcnt[i] <= weight[i];
  - os_cnt + len_i + 1 <= reg2dp_wr_os_cnt + 1 (OS_W-bit compare, no wrap).
- Round reset: if some client requests and has OS room but every such client has gcnt > weight, all gcnt clear to 0 that cycle. All OS-fitting requesters are then treated as eligible.
- Winner: first eligible client searching from rr_ptr+1 upward, wrapping at NUM_CLIENT-1 to 0. Selection is combinational, 0-cycle latency.
- IDLE outputs:
  - out_cmd_valid = winner exists; sel = winner.
  - cmd_ready[winner] = out_cmd_ready; all other cmd_ready = 0.
- Cmd accept (out_cmd_valid & out_cmd_ready):
  - rr_ptr ← winner; gcnt[winner] saturating-increments to 9'h1FF;
  - sel_r ← winner; beats_left ← len; os_cnt += len+1; state → DATA.
- DATA outputs:
  - out_cmd_valid = 0; sel = sel_r.
  - out_dat_valid = dat_valid[sel_r]; dat_ready[sel_r] = out_dat_ready; all other dat_ready = 0.
- DATA progress: each accepted beat decrements beats_left. The beat accepted with beats_left==0 returns state → IDLE.
  - This gives one IDLE cycle between packets (no same-cycle re-grant).
- Data in IDLE: dat_ready is 0 for all clients.
- os_cnt update:
  - eg2ig_axi_vld subtracts eg2ig_axi_len+1, saturating at 0.
  - Simultaneous grant and completion apply the net delta in one cycle.
- Register changes: weight and os limit changes are sampled live and affect only the next arbitration. They never interrupt a packet in flight.
- Waiting: no client is eligible because of the OS limit → out_cmd_valid stays 0 until completions free room. This is not an error.
- Dropped request: cmd_valid deasserted before grant is legal and is simply not selected.
- Reset mid-packet: abandons the packet; all state returns to reset values immediately.

Optional Feature:
NVDLA_MCIF_WR_SCHED_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0], a saturating count of IDLE cycles with any cmd_valid and no winner owing to the OS limit. Adds input stall_cnt_clr, a synchronous clear that has priority over increment. Reset value 0.
- Undefined: neither port exists and there is no added logic.

Decomposition:
- Shared package nv_nvdla_mcif_wr_pkg:
  - state enum (IDLE, DATA);
  - NUM_CLIENT, LEN_W, OS_W constants;
  - client index constants.
- One sub-module, nv_nvdla_mcif_wr_rr_pick: combinational rotating priority picker (req vector, rr_ptr → one-hot + index).

Test Plan:
- Single client 2, len=3, os limit 255, out_* always ready → cmd accepted cycle 1; 4 data beats; sel=2 throughout; os_cnt=4 until completions.
- Clients 0 and 1 always requesting len=0, weights 2 and 0 → grant pattern 0,0,0,1 repeating.
- reg2dp_wr_os_cnt=3, client 0 requesting len=3 twice → second cmd held (out_cmd_valid=0). One eg2ig_axi_vld with len=3 → grant the next cycle.
- Grant and completion in the same cycle (grant len=1, completion len=0, os_cnt was 2) → os_cnt=3.
- out_dat_ready low 5 cycles mid-packet while another client raises cmd_valid → no cmd_ready asserted until the last beat completes.
- Reset asserted in DATA with beats_left=2 → all outputs 0 asynchronously; after release the first grant starts from client 0.
